// File: rtl/tile_arbiter.sv
// Tile-map RAM arbiter: display fetch every 8th scan pixel, round-robin writers elsewhere.
// Optional macro TILE_ARB_BLANK_ONLY_EN restricts writer grants to the BLANK state.
module tile_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_enable,
  input  logic        v_sync,
  input  logic [8:0]  h_pos,
  input  logic [8:0]  v_pos,
  input  logic        req0,
  input  logic        req1,
  input  logic [10:0] addr0,
  input  logic [10:0] addr1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        err_oob,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  tile_q,
  output logic        tile_valid,
  output logic        frame_tick
);

  localparam logic [10:0] MAX_ADDR = 11'd1139;

  typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rr;
  logic [1:0]  r_vld_pipe;
  logic [7:0]  r_tile_q;
  logic        r_vs;

  logic [10:0] w_row, w_col, w_disp_addr;
  logic        w_fetch, w_wslot, w_pick1;
  logic        w_unused;

  assign w_unused = ^v_pos[2:0];

  // row*38 as row*32 + row*4 + row*2
  assign w_row       = {5'd0, v_pos[8:3]};
  assign w_col       = {5'd0, h_pos[8:3]};
  assign w_disp_addr = (w_row << 5) + (w_row << 2) + (w_row << 1) + w_col;

  assign w_fetch = (r_state == SCAN) && vga_enable && (h_pos[2:0] == 3'd0);
`ifdef TILE_ARB_BLANK_ONLY_EN
  assign w_wslot = (r_state == BLANK) && !w_fetch;
`else
  assign w_wslot = !w_fetch;
`endif

  // rr=1 means requester 1 wins a tie
  assign w_pick1 = req1 && (!req0 || r_rr);

  always_comb begin
    w_state_nxt = vga_enable ? SCAN : BLANK;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    err_oob     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = w_disp_addr;
    mem_wdata   = 8'd0;
    if (!rst && w_wslot && (req0 || req1)) begin
      if (w_pick1) begin
        gnt1      = 1'b1;
        mem_addr  = addr1;
        mem_wdata = data1;
      end else begin
        gnt0      = 1'b1;
        mem_addr  = addr0;
        mem_wdata = data0;
      end
      if (mem_addr <= MAX_ADDR) mem_we  = 1'b1;
      else                      err_oob = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= BLANK;
      r_rr       <= 1'b0;
      r_vld_pipe <= 2'b00;
      r_tile_q   <= 8'd0;
      r_vs       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (gnt0 || gnt1) r_rr <= gnt0;
      r_vld_pipe <= {r_vld_pipe[0], w_fetch};
      if (r_vld_pipe[0]) r_tile_q <= mem_rdata;
      r_vs       <= v_sync;
    end
  end

  assign tile_valid = r_vld_pipe[1];
  assign tile_q     = r_tile_q;
  assign frame_tick = v_sync && !r_vs && !rst;

endmodule

// File: tb/tb_tile_arbiter.sv
// Directed-vector bench for tile_arbiter (default build; blank-only sequence under its macro).
module tb_tile_arbiter;

  logic        clk = 1'b0;
  logic        rst, vga_enable, v_sync;
  logic [8:0]  h_pos, v_pos;
  logic        req0, req1;
  logic [10:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic        gnt0, gnt1, err_oob, mem_we, tile_valid, frame_tick;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, tile_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tile_arbiter dut (
    .clk(clk), .rst(rst), .vga_enable(vga_enable), .v_sync(v_sync),
    .h_pos(h_pos), .v_pos(v_pos), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .err_oob(err_oob), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tile_q(tile_q), .tile_valid(tile_valid), .frame_tick(frame_tick)
  );

  typedef struct {
    logic        vga;
    logic [8:0]  h, v;
    logic        r0, r1;
    logic [10:0] a0;
    logic [7:0]  d0;
    logic [10:0] a1;
    logic [7:0]  d1, rd;
    logic        eg0, eg1, ewe, eerr, chka;
    logic [10:0] eaddr;
    logic [7:0]  ewd;
    logic        etv;
    logic [7:0]  etq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vga, logic [8:0] h, logic [8:0] v, logic r0, logic r1,
                              logic [10:0] a0, logic [7:0] d0, logic [10:0] a1, logic [7:0] d1,
                              logic [7:0] rd, logic eg0, logic eg1, logic ewe, logic eerr,
                              logic chka, logic [10:0] eaddr, logic [7:0] ewd,
                              logic etv, logic [7:0] etq);
    vec_t t;
    t.vga = vga; t.h = h; t.v = v; t.r0 = r0; t.r1 = r1;
    t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.rd = rd;
    t.eg0 = eg0; t.eg1 = eg1; t.ewe = ewe; t.eerr = eerr;
    t.chka = chka; t.eaddr = eaddr; t.ewd = ewd; t.etv = etv; t.etq = etq;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // inputs change 1ns after the edge, outputs sampled mid-cycle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_enable = 0; v_sync = 0; h_pos = 0; v_pos = 0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0; mem_rdata = 0;
  endtask

  int w0, w1, max0, max1, bad_slot;

  initial begin
    rst = 1;
    idle_inputs();
    req0 = 1; req1 = 1; addr0 = 11'd10; addr1 = 11'd20;
    #1;
    for (int i = 0; i < 2; i++) begin
      #4;
      chk($sformatf("rst_gnt0_%0d", i), gnt0, 0);
      chk($sformatf("rst_gnt1_%0d", i), gnt1, 0);
      chk($sformatf("rst_we_%0d", i), mem_we, 0);
      step();
    end
    chk("rst_tile_valid", tile_valid, 0);
    chk("rst_tile_q", tile_q, 0);
    chk("rst_frame_tick", frame_tick, 0);
    rst = 0;

    //            vga h    v  r0 r1 a0     d0     a1     d1     rd     g0 g1 we er ca addr   wd     tv tq
    vecs.push_back(mk(0, 0,   0, 1, 1, 100,  8'h11, 200,  8'h22, 0,     1, 0, 1, 0, 1, 100,  8'h11, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 1, 100,  8'h11, 200,  8'h22, 0,     0, 1, 1, 0, 1, 200,  8'h22, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 1, 101,  8'h33, 200,  8'h22, 0,     1, 0, 1, 0, 1, 101,  8'h33, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 1, 101,  8'h33, 201,  8'h44, 0,     0, 1, 1, 0, 1, 201,  8'h44, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 1139, 8'h55, 0,    0,     0,     1, 0, 1, 0, 1, 1139, 8'h55, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 5,    8'h5A, 0,    0,     0,     1, 0, 1, 0, 1, 5,    8'h5A, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 1, 0,    0,     1140, 8'h66, 0,     0, 1, 0, 1, 1, 1140, 8'h66, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0,    0,     0,    0,     0,     0, 0, 0, 0, 0, 0,    0,     0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 0, 2047, 8'h01, 0,    0,     0,     1, 0, 0, 1, 1, 2047, 8'h01, 0, 0));
    vecs.push_back(mk(1, 16,  9, 1, 0, 7,    8'h02, 0,    0,     0,     1, 0, 1, 0, 1, 7,    8'h02, 0, 0));
    vecs.push_back(mk(1, 16,  9, 1, 1, 7,    8'h02, 300,  8'h77, 0,     0, 0, 0, 0, 1, 40,   0,     0, 0));
    vecs.push_back(mk(1, 17,  9, 1, 1, 7,    8'h02, 300,  8'h77, 8'hA5, 0, 1, 1, 0, 1, 300,  8'h77, 0, 0));
    vecs.push_back(mk(1, 18,  9, 1, 1, 400,  8'h88, 300,  8'h77, 0,     1, 0, 1, 0, 1, 400,  8'h88, 1, 8'hA5));
    vecs.push_back(mk(1, 296, 237, 1, 1, 400, 8'h88, 500, 8'h99, 0,     0, 0, 0, 0, 1, 1139, 0,     0, 0));
    vecs.push_back(mk(0, 297, 237, 1, 1, 400, 8'h88, 500, 8'h99, 8'h3C, 0, 1, 1, 0, 1, 500,  8'h99, 0, 0));
    vecs.push_back(mk(0, 0,   0, 1, 1, 600,  8'hAA, 500,  8'h99, 0,     1, 0, 1, 0, 1, 600,  8'hAA, 1, 8'h3C));

    foreach (vecs[i]) begin
      vga_enable = vecs[i].vga; h_pos = vecs[i].h; v_pos = vecs[i].v;
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      addr0 = vecs[i].a0; data0 = vecs[i].d0; addr1 = vecs[i].a1; data1 = vecs[i].d1;
      mem_rdata = vecs[i].rd;
      #4;
      chk($sformatf("v%0d_gnt0", i), gnt0, vecs[i].eg0);
      chk($sformatf("v%0d_gnt1", i), gnt1, vecs[i].eg1);
      chk($sformatf("v%0d_we", i), mem_we, vecs[i].ewe);
      chk($sformatf("v%0d_err", i), err_oob, vecs[i].eerr);
      if (vecs[i].chka) chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].eaddr);
      if (vecs[i].eg0 || vecs[i].eg1) chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].ewd);
      chk($sformatf("v%0d_tvalid", i), tile_valid, vecs[i].etv);
      if (vecs[i].etv) chk($sformatf("v%0d_tq", i), tile_q, vecs[i].etq);
      step();
    end

    // frame tick: one pulse on the rising edge, none while held
    idle_inputs();
    #4; chk("ft_low", frame_tick, 0); step();
    v_sync = 1;
    #4; chk("ft_pulse", frame_tick, 1); step();
    for (int i = 0; i < 3; i++) begin
      #4; chk($sformatf("ft_hold_%0d", i), frame_tick, 0); step();
    end
    v_sync = 0;

    // reset mid-request: no grant under reset, held request granted after
    rst = 1; req1 = 1; addr1 = 11'd33; data1 = 8'h5C;
    #4; chk("rreq_gnt1_rst", gnt1, 0); step();
    rst = 0;
    #4; chk("rreq_gnt1_after", gnt1, 1); chk("rreq_we_after", mem_we, 1); step();
    req1 = 0;

    // reset mid-fetch suppresses the pending tile_valid
    vga_enable = 1; h_pos = 1; v_pos = 0; step();
    h_pos = 8; mem_rdata = 8'hE7;
    #4; chk("rfetch_addr", mem_addr, 1); chk("rfetch_we", mem_we, 0); step();
    rst = 1; vga_enable = 0; h_pos = 9;
    #4; step();
    rst = 0;
    #4; chk("rfetch_tvalid0", tile_valid, 0); step();
    #4; chk("rfetch_tvalid1", tile_valid, 0); step();

    // fairness and fetch-slot exclusivity with both requesters held
    vga_enable = 1; req0 = 1; req1 = 1; addr0 = 11'd1; addr1 = 11'd2;
    w0 = 0; w1 = 0; max0 = 0; max1 = 0; bad_slot = 0;
    h_pos = 9'd7; step();
    for (int i = 0; i < 32; i++) begin
      h_pos = 9'(i);
      #4;
      if (h_pos[2:0] == 3'd0 && (gnt0 || gnt1)) bad_slot++;
      if (gnt0 && gnt1) bad_slot++;
      w0 = gnt0 ? 0 : w0 + 1;
      w1 = gnt1 ? 0 : w1 + 1;
      if (w0 > max0) max0 = w0;
      if (w1 > max1) max1 = w1;
      step();
    end
    chk("fair_bad_slot", bad_slot, 0);
    chk("fair_wait0_le3", (max0 <= 3), 1);
    chk("fair_wait1_le3", (max1 <= 3), 1);

    // writer during SCAN: blank-only build defers it to the first BLANK-state cycle
    req1 = 0; vga_enable = 1; h_pos = 9'd1; step();
    h_pos = 9'd2; req0 = 1; addr0 = 11'd77;
`ifdef TILE_ARB_BLANK_ONLY_EN
    #4; chk("bo_scan_gnt0", gnt0, 0); step();
    vga_enable = 0; h_pos = 9'd3;
    #4; chk("bo_fall_gnt0", gnt0, 0); step();
    #4; chk("bo_blank_gnt0", gnt0, 1); step();
`else
    #4; chk("scan_gnt0", gnt0, 1); chk("scan_addr", mem_addr, 77); step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tile_arbiter.md
TILE_ARBITER -- requirements
Module: tile_arbiter

Interface
REQ-001 clk  input  1  system clock, 12 MHz, shared with the VGA timing generator.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 vga_enable  input  1  active-video flag from the timing generator.
REQ-004 v_sync  input  1  vertical sync from the timing generator, high during the visible frame.
REQ-005 h_pos, v_pos  input  9 each  current pixel position: 0..298 horizontal, 0..237 vertical.
REQ-006 req0, req1  input  1 each  write requests; req0 is game logic, req1 is sprite engine.
REQ-007 addr0, addr1  input  11 each  tile-map write addresses.
REQ-008 data0, data1  input  8 each  tile indices to write.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant pulses.
REQ-010 err_oob  output  1  one-cycle pulse when a granted write is dropped for an out-of-range address.
REQ-011 mem_addr  output  11  address to the single-port tile RAM.
REQ-012 mem_we  output  1  write enable to the tile RAM.
REQ-013 mem_wdata  output  8  write data to the tile RAM.
REQ-014 mem_rdata  input  8  RAM read data, valid 1 cycle after the address is presented.
REQ-015 tile_q  output  8  fetched tile index for the display pipeline.
REQ-016 tile_valid  output  1  tile_q valid strobe.
REQ-017 frame_tick  output  1  one-cycle pulse marking the start of a frame.

Function
REQ-018 Tile map: 38x30 tiles of 8x8 pixels; address = (v_pos>>3)*38 + (h_pos>>3); valid range 0..1139.
REQ-019 The *38 multiply SHALL be built from shifts and adds (x32+x4+x2); no multiplier inference.
REQ-020 FSM states:
- SCAN: vga_enable=1.
- BLANK: vga_enable=0.
- Each cycle, state <= vga_enable ? SCAN : BLANK.
REQ-021 Display fetch slot:
- Condition: state SCAN, vga_enable=1 and h_pos[2:0]==0.
- mem_addr = display address, mem_we=0.
- Writers are never granted in this slot.
REQ-022 Fetch result: tile_valid=1 and tile_q=mem_rdata exactly 2 cycles after the fetch slot (1 cycle RAM latency, 1 output register).
REQ-023 Writer slots: every cycle that is not a fetch slot.
REQ-024 Writer selection in a writer slot:
- Only one requester active: grant it.
- Both active: grant the one selected by the round-robin pointer rr.
- Neither active: mem_we=0, no grant.
REQ-025 After any grant, rr SHALL point to the requester that was not granted.
REQ-026 On grant to requester n:
- gnt_n is asserted combinationally in the same cycle.
- mem_addr = addr_n, mem_wdata = data_n.
- mem_we=1 if addr_n<=1139.
- Otherwise mem_we=0 and err_oob=1 in that cycle.
REQ-027 Handshake: a requester holds req, addr and data stable until it samples gnt=1; it may deassert req the cycle after.
REQ-028 Fairness bound: with both requesters held high continuously, neither SHALL wait more than 3 cycles for a grant.
REQ-029 frame_tick=1 for exactly one cycle on the v_sync 0->1 edge, detected via a registered copy of v_sync.

Reset
REQ-030 While rst=1, at the next clk edge:
- gnt0, gnt1, mem_we, err_oob, tile_valid, frame_tick = 0.
- tile_q = 0.
- rr = 0 (req0 preferred).
- state = BLANK.
- v_sync register = 0.
REQ-031 A reset asserted mid-fetch SHALL suppress the pending tile_valid.
REQ-032 A reset asserted mid-request SHALL produce no grant during reset; a held request is granted normally after release.

Configuration
REQ-033 Macro TILE_ARB_BLANK_ONLY_EN:
- Defined: writers are granted only while state=BLANK (tear-free updates); all SCAN cycles that are not fetch slots are idle.
- Undefined: writers use all non-fetch cycles per REQ-023.

Verification
REQ-034 Reset: rst=1 for 2 cycles with req0=req1=1 -> gnt0=gnt1=0 and mem_we=0 throughout; first grant after release goes to req0.
REQ-035 Round-robin: both requests held, vga_enable=0 -> gnt pattern 0,1,0,1...; each write appears on mem_addr/mem_wdata in its grant cycle.
REQ-036 Fetch: h_pos=16, v_pos=9, vga_enable=1 -> mem_addr=40, mem_we=0, no grant that cycle; tile_valid=1 two cycles later with tile_q=mem_rdata.
REQ-037 Out of range: req1=1, addr1=1140 -> gnt1=1, err_oob=1, mem_we=0.
REQ-038 Blank-only mode: with TILE_ARB_BLANK_ONLY_EN defined, req0 during SCAN -> no gnt0 until vga_enable falls, then gnt0 in the first BLANK cycle.
REQ-039 Frame tick: drive v_sync 0->1 -> frame_tick=1 for exactly 1 cycle; holding v_sync high -> no further pulses.
